// File: rtl/div_mlt.sv
// 32-bit iterative multiply / divide unit.
// Shift-add multiply, restoring divide, signed or unsigned, 33-edge latency.
module div_mlt (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_mul,
  input  logic        i_sign,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_zero,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_b;
  logic        r_mul;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_divz;
  logic [31:0] r_o_hi;
  logic [31:0] r_o_lo;
  logic        r_o_zero;
  logic        r_busy;

  logic        w_divz;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_addend;
  logic [32:0] w_sum;
  logic [32:0] w_sh;
  logic [31:0] w_diff;
  logic        w_ge;
  logic [63:0] w_prod;
  logic [63:0] w_prod_c;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_divz   = ~i_mul & (i_B == 32'd0);
  assign w_a_neg  = i_sign & i_A[31];
  assign w_b_neg  = i_sign & i_B[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - i_A) : i_A;
  assign w_b_mag  = w_b_neg ? (32'd0 - i_B) : i_B;

  assign w_addend = r_lo[0] ? r_b : 32'd0;
  assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};

  assign w_sh     = {r_hi, r_lo[31]};
  assign w_ge     = (w_sh >= {1'b0, r_b});
  assign w_diff   = w_sh[31:0] - r_b;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_c = r_neg_q ? (64'd0 - w_prod) : w_prod;
  assign w_q      = r_neg_q ? (32'd0 - r_lo) : r_lo;
  assign w_r      = r_neg_r ? (32'd0 - r_hi) : r_hi;

  assign o_hi   = r_o_hi;
  assign o_lo   = r_o_lo;
  assign o_zero = r_o_zero;
  assign o_busy = r_busy;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next state: divide by zero skips the iteration phase
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_en) w_next = w_divz ? FINISH : CALC;
      end
      CALC: begin
        if (r_cnt == 5'd31) w_next = FINISH;
      end
      FINISH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, one iteration per edge, result write-back
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= 5'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_b      <= 32'd0;
      r_mul    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_divz   <= 1'b0;
      r_o_hi   <= 32'd0;
      r_o_lo   <= 32'd0;
      r_o_zero <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_en) begin
            r_mul    <= i_mul;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_divz   <= w_divz;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b1;
            r_o_zero <= 1'b0;
            r_hi     <= w_divz ? i_A : 32'd0;
            r_lo     <= i_mul ? w_b_mag : w_a_mag;
            r_b      <= i_mul ? w_a_mag : w_b_mag;
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_mul) begin
            r_hi <= w_sum[32:1];
            r_lo <= {w_sum[0], r_lo[31:1]};
          end else begin
            r_hi <= w_ge ? w_diff : w_sh[31:0];
            r_lo <= {r_lo[30:0], w_ge};
          end
        end
        FINISH: begin
          r_busy <= 1'b0;
          if (r_divz) begin
            r_o_hi   <= r_hi;
            r_o_lo   <= 32'hFFFF_FFFF;
            r_o_zero <= 1'b1;
          end else if (r_mul) begin
            r_o_hi <= w_prod_c[63:32];
            r_o_lo <= w_prod_c[31:0];
          end else begin
            r_o_hi <= w_r;
            r_o_lo <= w_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_mlt.sv
// Self-checking bench for div_mlt.
// Directed vectors plus random ops against a 64-bit arithmetic model.
module tb_div_mlt;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mul;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_zero;
  logic        o_busy;

  int checks;
  int failures;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  div_mlt dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_en   (en),
    .i_mul  (mul),
    .i_sign (sgn),
    .i_A    (a),
    .i_B    (b),
    .o_hi   (o_hi),
    .o_lo   (o_lo),
    .o_zero (o_zero),
    .o_busy (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic m, input logic s,
                                input logic [31:0] x,
                                input logic [31:0] y,
                                output logic [31:0] hi,
                                output logic [31:0] lo,
                                output logic z);
    longint sx;
    longint sy;
    longint p;
    longint q;
    longint r;
    sx = s ? longint'($signed(x)) : longint'({32'd0, x});
    sy = s ? longint'($signed(y)) : longint'({32'd0, y});
    z  = 1'b0;
    if (m) begin
      p  = sx * sy;
      hi = p[63:32];
      lo = p[31:0];
    end else if (y == 32'd0) begin
      z  = 1'b1;
      hi = x;
      lo = 32'hFFFF_FFFF;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  task automatic run_op(input string tag,
                        input logic m, input logic s,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [31:0] ehi,
                        input logic [31:0] elo,
                        input logic ez,
                        input bit hold);
    int lat;
    int cnt;
    lat = (!m && y == 32'd0) ? 1 : 33;
    @(negedge clk);
    mul = m;
    sgn = s;
    a   = x;
    b   = y;
    en  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      en  = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      mul = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
    end
    check({tag, ".busy"}, 64'(o_busy), 64'd1);
    check({tag, ".zclr"}, 64'(o_zero), 64'd0);
    check({tag, ".hold"}, {o_hi, o_lo}, {prev_hi, prev_lo});
    cnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (!o_busy) break;
      if (cnt == 16)
        check({tag, ".mid"}, {o_hi, o_lo}, {prev_hi, prev_lo});
    end
    if (!hold) en = 1'b0;
    check({tag, ".lat"}, 64'(cnt), 64'(lat));
    check({tag, ".hi"}, 64'(o_hi), 64'(ehi));
    check({tag, ".lo"}, 64'(o_lo), 64'(elo));
    check({tag, ".z"}, 64'(o_zero), 64'(ez));
    prev_hi = ehi;
    prev_lo = elo;
  endtask

  initial begin
    logic [31:0] mhi;
    logic [31:0] mlo;
    logic        mz;
    logic        rm;
    logic        rs;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    checks   = 0;
    failures = 0;
    prev_hi  = 32'd0;
    prev_lo  = 32'd0;
    rst_n    = 1'b0;
    en       = 1'b0;
    mul      = 1'b0;
    sgn      = 1'b0;
    a        = 32'd0;
    b        = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.hi", 64'(o_hi), 64'd0);
    check("rst.lo", 64'(o_lo), 64'd0);
    check("rst.z", 64'(o_zero), 64'd0);
    check("rst.busy", 64'(o_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("sdiv", 1'b0, 1'b1, 32'h6FFF7660, 32'h0000CCDD,
           32'h000034BC, 32'h00008BF4, 1'b0, 1'b0);
    run_op("div0", 1'b0, 1'b0, 32'h6FFF7660, 32'h0,
           32'h6FFF7660, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("smul1", 1'b1, 1'b1, 32'h6FFF7660, 32'h0000CCDD,
           32'h000059A0, 32'h41DDB0E0, 1'b0, 1'b1);
    run_op("smul2", 1'b1, 1'b1, 32'h6FFF7660, 32'h0000CCDD,
           32'h000059A0, 32'h41DDB0E0, 1'b0, 1'b1);
    en = 1'b0;
    run_op("umulff", 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    run_op("smulff", 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'h0, 32'h1, 1'b0, 1'b0);
    run_op("sdivm7", 1'b0, 1'b1, 32'hFFFFFFF9, 32'h2,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("sdivmin", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF,
           32'h0, 32'h80000000, 1'b0, 1'b0);

    // abort a divide mid-flight with an asynchronous reset pulse
    @(negedge clk);
    mul = 1'b0;
    sgn = 1'b1;
    a   = 32'h6FFF7660;
    b   = 32'h0000CCDD;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst.hi", 64'(o_hi), 64'd0);
    check("arst.lo", 64'(o_lo), 64'd0);
    check("arst.z", 64'(o_zero), 64'd0);
    check("arst.busy", 64'(o_busy), 64'd0);
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post", 1'b0, 1'b1, 32'h6FFF7660, 32'h0000CCDD,
           32'h000034BC, 32'h00008BF4, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rm  = 1'($urandom_range(0, 1));
      rs  = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) rb = 32'd0;
      if (sel == 1) rb = 32'hFFFFFFFF;
      if (sel == 2) ra = 32'h80000000;
      if (sel == 3) rb = 32'($urandom_range(1, 15));
      if (sel == 4) ra = 32'($urandom_range(0, 100));
      model(rm, rs, ra, rb, mhi, mlo, mz);
      run_op("rnd", rm, rs, ra, rb, mhi, mlo, mz, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_mlt.md
DIV_MLT -- requirements
Module: div_mlt

Interface
REQ-001 The block SHALL have one clock, i_clk, and an asynchronous, active-low reset, i_rst_n.
REQ-002 Port list SHALL be (name, direction, width, meaning):
- i_clk, in, 1, clock; all state changes on its rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_en, in, 1, start request, level-sampled.
- i_mul, in, 1, 1 = multiply, 0 = divide.
- i_sign, in, 1, 1 = two's-complement operands, 0 = unsigned.
- i_A, in, 32, multiplicand / dividend.
- i_B, in, 32, multiplier / divisor.
- o_hi, out, 32, product[63:32] or remainder.
- o_lo, out, 32, product[31:0] or quotient.
- o_zero, out, 1, divide-by-zero flag of last operation.
- o_busy, out, 1, operation in progress.

Function
REQ-003 FSM states SHALL be IDLE, CALC and FINISH.
REQ-004 Start SHALL occur on a rising edge where i_en=1 and the state is IDLE.
- At the start edge, i_A, i_B, i_mul and i_sign SHALL be latched, o_busy SHALL be set to 1, and o_zero SHALL be cleared.
- i_en and operand changes SHALL be ignored while o_busy=1.
REQ-005 Signed mode SHALL convert operands to magnitudes at the start edge and record the result signs. Unsigned mode SHALL use the operands as-is.
REQ-006 CALC SHALL run exactly 32 iterations, one bit per edge, on the magnitudes:
- Multiply: shift-add.
- Divide: restoring division.
REQ-007 FINISH SHALL do three things on one edge: apply sign correction, write o_hi and o_lo, and clear o_busy. The state SHALL then return to IDLE.
REQ-008 Latency SHALL be 33 edges: start at edge N, results valid and o_busy=0 after edge N+33.
REQ-009 Multiply SHALL give {o_hi,o_lo} = full 64-bit product (signed or unsigned). o_zero SHALL be 0 after a multiply.
REQ-010 Divide SHALL give o_lo = quotient and o_hi = remainder.
- Signed quotient SHALL truncate toward zero.
- Signed remainder SHALL take the dividend's sign.
REQ-011 Signed 0x80000000 / 0xFFFFFFFF SHALL give o_lo=0x80000000 and o_hi=0, with o_zero=0.
REQ-012 Divide by zero (latched B=0, i_mul=0) SHALL bypass CALC and complete at edge N+1 with:
- o_zero=1
- o_hi = latched A
- o_lo = 0xFFFFFFFF
- o_busy=0
REQ-013 o_hi, o_lo and o_zero SHALL hold their values until the next FINISH or divide-by-zero completion. Intermediate values SHALL NOT appear on them.
REQ-014 If i_en is still 1 at the edge where the state is IDLE again, a new operation SHALL start with the current inputs (back-to-back operation).

Reset
REQ-015 i_rst_n=0 SHALL immediately force the following, independent of i_clk: state IDLE, o_hi=0, o_lo=0, o_zero=0, o_busy=0, all internal registers cleared.
REQ-016 Reset asserted mid-operation SHALL abort the operation without producing a result.
REQ-017 The first start after reset release SHALL be accepted on the first rising edge with i_rst_n=1 and i_en=1.

Verification
REQ-018 Signed divide: A=0x6FFF7660, B=0x0000CCDD, i_mul=0, i_sign=1, one-cycle i_en pulse -> after 33 edges o_lo=0x00008BF4, o_hi=0x000034BC, o_zero=0.
REQ-019 Divide by zero: A=0x6FFF7660, B=0, i_mul=0 -> next edge o_zero=1, o_hi=0x6FFF7660, o_lo=0xFFFFFFFF, o_busy=0.
REQ-020 Signed multiply: A=0x6FFF7660, B=0x0000CCDD, i_mul=1, i_sign=1, i_en held high -> o_hi=0x000059A0, o_lo=0x41DDB0E0, o_zero=0, and the operation repeats with identical results.
REQ-021 A=B=0xFFFFFFFF, i_mul=1 -> with i_sign=0: o_hi=0xFFFFFFFE, o_lo=0x00000001; with i_sign=1: o_hi=0, o_lo=1.
REQ-022 Signed divide A=0xFFFFFFF9 (-7), B=2 -> o_lo=0xFFFFFFFD, o_hi=0xFFFFFFFF. Also A=0x80000000, B=0xFFFFFFFF -> o_lo=0x80000000, o_hi=0.
REQ-023 Reset pulse at edge N+10 of a divide -> all outputs 0 immediately, o_busy=0. A new start then completes correctly 33 edges later.
